matled_varredura: RTL and testbench

MATLED_VARREDURA -- requirements
Module: matled_varredura

---
 rtl/matled_varredura.sv | 130 +++++++++++++
 tb/tb_matled_varredura.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/matled_varredura.sv
// Column-multiplexed LED matrix scanner with a double-buffered frame image.
// The image only swaps at frame boundaries, so a frame never shows mixed data.
module matled_varredura #(
    parameter int ROWS  = 4,
    parameter int COLS  = 2,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] chaves,
    output logic [ROWS-1:0]      l,
    output logic [COLS-1:0]      c,
    output logic                 frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    if (ROWS < 1 || COLS < 1 || BLANK < 0 || DIV <= BLANK) begin : g_bad_params
        $error("matled_varredura: illegal parameters (need ROWS>=1, COLS>=1, BLANK>=0, DIV>BLANK)");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                 state;
    logic [CW-1:0]          col;
    logic [PW-1:0]          pre;
    logic [ROWS*COLS-1:0]   shadow;
    logic [ROWS*COLS-1:0]   active;
    logic                   pending;

    // With no dead time a new slot goes straight to SHOW.
    localparam state_t SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    logic boundary;

    always_comb begin
        boundary = 1'b0;
        if (enable) begin
            if (state == ST_IDLE)
                boundary = 1'b1;
            else if (state == ST_SHOW && pre == PRE_LAST && col == COL_LAST)
                boundary = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            col     <= '0;
            pre     <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                shadow <= chaves;

            // A load landing on the boundary edge bypasses the shadow copy.
            if (boundary) begin
                if (load) begin
                    active  <= chaves;
                    pending <= 1'b0;
                end else if (pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                end
            end else if (load) begin
                pending <= 1'b1;
            end

            if (!enable) begin
                state <= ST_IDLE;
                col   <= '0;
                pre   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= SLOT_START;
                        col   <= '0;
                        pre   <= '0;
                    end
                    ST_BLANK: begin
                        pre <= pre + PW'(1);
                        if (pre == BLANK_LAST)
                            state <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (pre == PRE_LAST) begin
                            pre   <= '0;
                            state <= SLOT_START;
                            col   <= (col == COL_LAST) ? '0 : col + CW'(1);
                        end else begin
                            pre <= pre + PW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        col   <= '0;
                        pre   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        c = '0;
        l = '1;
        if (state == ST_SHOW) begin
            c[col] = 1'b1;
            for (int r = 0; r < ROWS; r++)
                l[r] = ~active[r*COLS + int'(col)];
        end
    end

    assign frame_done = (state == ST_SHOW) && (col == COL_LAST) && (pre == PRE_LAST);

endmodule

// File: tb/tb_matled_varredura.sv
// Randomized and directed bench for matled_varredura; the reference model tracks
// the scan as a single position within the frame and derives column/slot from it.
module tb_matled_varredura;

    localparam int ROWS  = 4;
    localparam int COLS  = 2;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = COLS * DIV;
    localparam int N     = ROWS * COLS;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic           load;
    logic [N-1:0]   chaves;
    logic [ROWS-1:0] l;
    logic [COLS-1:0] c;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    bit           mRun;
    int           mT;
    logic [N-1:0] mAct;
    logic [N-1:0] mShd;
    bit           mPend;

    matled_varredura #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .chaves     (chaves),
        .l          (l),
        .c          (c),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Reference: position mT counts cycles since the frame began.
    task automatic modelStep(input bit rst, input bit en, input bit ld, input logic [N-1:0] ch);
        bit boundary;
        boundary = 1'b0;
        if (rst) begin
            mRun = 0; mT = 0; mAct = '0; mShd = '0; mPend = 0;
            return;
        end
        if (!en) begin
            mRun = 0; mT = 0;
        end else if (!mRun) begin
            mRun = 1; mT = 0; boundary = 1'b1;
        end else begin
            mT = mT + 1;
            if (mT == FRAME) begin
                mT = 0; boundary = 1'b1;
            end
        end
        if (ld) mShd = ch;
        if (boundary) begin
            if (ld) mAct = ch;
            else if (mPend) mAct = mShd;
            mPend = 0;
        end else if (ld) begin
            mPend = 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [COLS-1:0] expC;
        logic [ROWS-1:0] expL;
        logic            expF;
        int col;
        expC = '0;
        expL = '1;
        col  = mT / DIV;
        if (mRun && (mT % DIV) >= BLANK) begin
            expC = COLS'(1) << col;
            for (int r = 0; r < ROWS; r++) expL[r] = ~mAct[r*COLS + col];
        end
        expF = mRun && (mT == FRAME - 1);
        checks++;
        assert (c === expC) else begin
            errors++;
            $error("[TB] FAIL %s c: got %b expected %b (t=%0d)", tag, c, expC, mT);
        end
        checks++;
        assert (l === expL) else begin
            errors++;
            $error("[TB] FAIL %s l: got %b expected %b (t=%0d)", tag, l, expL, mT);
        end
        checks++;
        assert (frame_done === expF) else begin
            errors++;
            $error("[TB] FAIL %s frame_done: got %b expected %b (t=%0d)", tag, frame_done, expF, mT);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit ld,
                                 input logic [N-1:0] ch, input string tag);
        reset  = rst;
        enable = en;
        load   = ld;
        chaves = ch;
        @(posedge clock);
        modelStep(rst, en, ld, ch);
        #1;
        checkOutput(tag);
    endtask

    // Runs the scan until the model sits at position pos, bounded.
    task automatic waitPos(input int pos, input string tag);
        int n;
        n = 0;
        while (!(mRun && mT == pos) && n < 4 * FRAME) begin
            applyStimulus(0, 1, 0, '0, tag);
            n++;
        end
        if (!(mRun && mT == pos)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got t=%0d expected t=%0d", tag, mT, pos);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b1; chaves = 8'hC3;
        mRun = 0; mT = 0; mAct = '0; mShd = '0; mPend = 0;

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 8'($urandom), "reset");
        applyStimulus(0, 0, 0, '0, "post_reset");

        applyStimulus(0, 0, 1, 8'b1010_0101, "load_a5");
        for (int i = 0; i < 2 * FRAME + 2; i++) applyStimulus(0, 1, 0, '0, "scan_a5");

        waitPos(3, "seek_col0");
        applyStimulus(0, 1, 1, 8'hFF, "midframe_ff");
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(0, 1, 0, '0, "scan_ff");

        waitPos(DIV + 4, "seek_col1_pre4");
        applyStimulus(0, 0, 0, '0, "disable");
        applyStimulus(0, 0, 0, '0, "idle");
        for (int i = 0; i < FRAME + 3; i++) applyStimulus(0, 1, 0, '0, "restart");

        waitPos(FRAME - 1, "seek_wrap");
        applyStimulus(0, 1, 1, 8'h0F, "wrap_load_0f");
        for (int i = 0; i < FRAME; i++) applyStimulus(0, 1, 0, '0, "scan_0f");

        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 150) == 0, ($urandom % 25) != 0,
                          ($urandom % 7) == 0, N'($urandom), "random");

        waitPos(5, "seek_reset_mid");
        applyStimulus(1, 1, 1, 8'hFF, "reset_midslot");
        applyStimulus(0, 1, 0, '0, "after_reset");
        for (int i = 0; i < FRAME; i++) applyStimulus(0, 1, 0, '0, "scan_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
